// File: rtl/req_ack_vr_bridge_pkg.sv
// Shared types and sizing helpers for the req/ack to ready/valid bridge.
package req_ack_vr_bridge_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, ACK} up_state_t;
  typedef enum logic [1:0] {EMPTY, VALID, BUBBLE} dn_state_t;

  // Occupancy counter width: must be able to represent DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of two).
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer advance on each push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/req_ack_vr_bridge.sv
// Pulsed req/ack command port in, buffered ready/valid stream out.
module req_ack_vr_bridge
  import req_ack_vr_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [DATA_W-1:0]         req_data,
  output logic                      ack,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      proto_err
);

  up_state_t         up_q, up_d;
  dn_state_t         dn_q, dn_d;
  logic              req_q, rise;
  logic              push, pop, hold_ld, can_push;
  logic              full, empty;
  logic [DATA_W-1:0] hold_q, push_data, pop_data;

  assign rise = req & ~req_q;
  // A pop in the same edge frees a slot, so a full FIFO can still accept.
  assign can_push  = ~full | pop;
  // A held request was captured earlier; a fresh one pushes straight from the port.
  assign push_data = (up_q == HOLD) ? hold_q : req_data;
  assign ack       = (up_q == ACK);
  assign out_valid = (dn_q == VALID);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (level)
  );

  // Registered req for rise detection, plus both FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      up_q  <= IDLE;
      dn_q  <= EMPTY;
    end else begin
      req_q <= req;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  // Upstream: accept a rising req, park it in HOLD while full, then ack once.
  always_comb begin
    up_d    = up_q;
    push    = 1'b0;
    hold_ld = 1'b0;
    case (up_q)
      IDLE: if (rise) begin
        if (can_push) begin
          push = 1'b1;
          up_d = ACK;
        end else begin
          hold_ld = 1'b1;
          up_d    = HOLD;
        end
      end
      HOLD: if (can_push) begin
        push = 1'b1;
        up_d = ACK;
      end
      ACK:     up_d = IDLE;
      default: up_d = IDLE;
    endcase
  end

  // Downstream: BUBBLE may reload immediately, so valid is low for exactly one cycle.
  always_comb begin
    dn_d = dn_q;
    pop  = 1'b0;
    case (dn_q)
      EMPTY, BUBBLE: begin
        if (!empty) begin
          pop  = 1'b1;
          dn_d = VALID;
        end else begin
          dn_d = EMPTY;
        end
      end
      VALID:   if (out_ready) dn_d = BUBBLE;
      default: dn_d = EMPTY;
    endcase
  end

  // Payload capture for a request that arrived while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold_q <= '0;
    else if (hold_ld) hold_q <= req_data;
  end

  // Output register only loads on pop, so data is frozen while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      out_data <= '0;
    else if (pop) out_data <= pop_data;
  end

  // Sticky protocol violation: overlapping request, or req high during ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else if ((rise && up_q != IDLE) || (req && ack)) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_req_ack_vr_bridge.sv
// Directed bench for req_ack_vr_bridge with hand-computed expectations.
module tb_req_ack_vr_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       proto_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  req_ack_vr_bridge #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Record every completed downstream transfer.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle req pulse; returns just after the edge that samples it.
  task automatic pulse_req(input logic [7:0] d);
    req      = 1'b1;
    req_data = d;
    step();
    req = 1'b0;
  endtask

  // Request plus its ack cycle, used to fill the FIFO.
  task automatic send(input logic [7:0] d);
    pulse_req(d);
    chk("send_ack", 32'(ack), 32'd1);
    step();
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single handshake
    out_ready = 1'b1;
    pulse_req(8'hA5);                      // edge T
    chk("hs_ack_T1", 32'(ack), 32'd1);
    chk("hs_level_T1", 32'(level), 32'd1);
    chk("hs_valid_T1", 32'(out_valid), 32'd0);
    step();                                // edge T+1: pop
    chk("hs_ack_T2", 32'(ack), 32'd0);
    chk("hs_valid_T2", 32'(out_valid), 32'd1);
    chk("hs_data_T2", 32'(out_data), 32'hA5);
    chk("hs_level_T2", 32'(level), 32'd0);
    step();                                // transfer
    chk("hs_valid_after", 32'(out_valid), 32'd0);
    exp_q.push_back(8'hA5);
    step();

    // Back-pressure fill: 0x01 sits in the output register, 0x02..0x05 fill the FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(8'(k));
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_valid", 32'(out_valid), 32'd1);
    chk("fill_data", 32'(out_data), 32'h01);
    pulse_req(8'h06);                      // full: parks in HOLD
    for (int k = 0; k < 3; k++) begin
      chk("hold_no_ack", 32'(ack), 32'd0);
      step();
    end
    chk("hold_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();                                // transfer 0x01
    chk("bp_bubble1", 32'(out_valid), 32'd0);
    step();                                // pop 0x02 + push 0x06
    chk("bp_hold_ack", 32'(ack), 32'd1);
    chk("bp_level_full", 32'(level), 32'd4);
    chk("bp_data2", 32'(out_data), 32'h02);
    step();
    chk("bp_ack_low", 32'(ack), 32'd0);
    chk("bp_bubble2", 32'(out_valid), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(k));
      step();
      chk("bp_bubble", 32'(out_valid), 32'd0);
    end
    chk("bp_level_end", 32'(level), 32'd0);
    for (int k = 1; k <= 6; k++) exp_q.push_back(8'(k));

    // Full with simultaneous pop: rise lands on the pop edge
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(8'h11 + 8'(k));
    chk("fp_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();                                // transfer 0x11
    req = 1'b1; req_data = 8'h16;
    step();                                // pop 0x12 and push 0x16
    req = 1'b0;
    chk("fp_ack", 32'(ack), 32'd1);
    chk("fp_level_same", 32'(level), 32'd4);
    chk("fp_data", 32'(out_data), 32'h12);
    drain(20);
    for (int k = 0; k < 6; k++) exp_q.push_back(8'h11 + 8'(k));

    // Overlapping req: second rise during ack is dropped
    pulse_req(8'h21);
    req = 1'b1; req_data = 8'h99;
    step();
    req = 1'b0;
    chk("ovl_err", 32'(proto_err), 32'd1);
    drain(10);
    exp_q.push_back(8'h21);

    // Valid hold under back-pressure
    out_ready = 1'b0;
    pulse_req(8'h5A);
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("vh_valid", 32'(out_valid), 32'd1);
      chk("vh_data", 32'(out_data), 32'h5A);
    end
    drain(6);
    exp_q.push_back(8'h5A);

    // Reset mid-operation with a request parked in HOLD
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(8'h31 + 8'(k));
    pulse_req(8'h36);
    step();
    chk("mr_hold_ack", 32'(ack), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mr_ack", 32'(ack), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_err", 32'(proto_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mr_post_ack", 32'(ack), 32'd0);
    out_ready = 1'b1;
    pulse_req(8'h3C);
    chk("mr_3c_ack", 32'(ack), 32'd1);
    drain(8);
    chk("mr_3c_err", 32'(proto_err), 32'd0);
    exp_q.push_back(8'h3C);

    // Whole delivered stream in order
    chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size()) chk("stream_item", 32'(got_q[k]), 32'(exp_q[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
